msg_keep_gen: RTL and testbench



---
 rtl/msg_keep_pkg.sv | 14 +
 rtl/msg_keep_gen_if.sv | 33 +++
 rtl/msg_keep_gen_len_to_mask.sv | 17 +
 rtl/msg_keep_gen.sv | 90 +++++++++
 tb/tb_msg_keep_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/msg_keep_pkg.sv
// Shared types for the streaming byte-keep mask generator.
package msg_keep_pkg;

  localparam int KEEP_W_DEF = 8;
  localparam int LEN_W_DEF  = 16;

  typedef logic [KEEP_W_DEF-1:0] keep_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fsm_e;

endpackage

// File: rtl/msg_keep_gen_if.sv
// Request (length/offset) and beat-mask channels of msg_keep_gen, plus FSM state for observation.
// Both channels: a transfer happens on the rising edge where valid and ready are both 1;
// the source holds its payload stable while valid=1 and ready=0.
interface msg_keep_gen_if #(
  parameter int LEN_W  = 16,
  parameter int KEEP_W = 8,
  parameter int OFF_W  = $clog2(KEEP_W),
  parameter int CNT_W  = $clog2(KEEP_W) + 1
);
  import msg_keep_pkg::*;

  logic              len_valid_i;
  logic [LEN_W-1:0]  len_i;
  logic [OFF_W-1:0]  off_i;
  logic              len_ready_o;
  logic              mask_valid_o;
  logic              mask_ready_i;
  logic [KEEP_W-1:0] mask_o;
  logic [CNT_W-1:0]  cnt_o;
  logic              last_o;
  fsm_e              state;

  modport slave (
    input  len_valid_i, len_i, off_i, mask_ready_i,
    output len_ready_o, mask_valid_o, mask_o, cnt_o, last_o, state
  );

  modport master (
    output len_valid_i, len_i, off_i, mask_ready_i,
    input  len_ready_o, mask_valid_o, mask_o, cnt_o, last_o, state
  );

endinterface

// File: rtl/msg_keep_gen_len_to_mask.sv
// Thermometer code: mask bit i is set when i < n.
module len_to_mask #(
  parameter int KEEP_W = 8,
  parameter int CNT_W  = $clog2(KEEP_W) + 1
) (
  input  logic [CNT_W-1:0]  n,
  output logic [KEEP_W-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      mask[i] = (i < int'(n));
    end
  end

endmodule

// File: rtl/msg_keep_gen.sv
// Streams one byte-keep mask per data beat for a message given by length and start lane.
module msg_keep_gen
  import msg_keep_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int KEEP_W = KEEP_W_DEF,
  parameter int OFF_W  = $clog2(KEEP_W),
  parameter int CNT_W  = $clog2(KEEP_W) + 1
) (
  input logic           clk,
  input logic           reset,
  msg_keep_gen_if.slave bus
);

  fsm_e              state;
  logic [LEN_W-1:0]  rem;
  logic              valid_q;
  logic [KEEP_W-1:0] mask_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;

  logic [OFF_W-1:0]  off;
  logic [CNT_W-1:0]  off_ext, room, cnt_first, first_hi, cnt_next;
  logic [KEEP_W-1:0] hi_mask, lo_mask, next_mask;
  logic              beat_take, accept;

  assign off = bus.off_i;

  // First beat is limited by the lanes left above the offset; later beats by a full beat.
  always_comb begin
    off_ext   = CNT_W'(off);
    room      = CNT_W'(KEEP_W) - off_ext;
    cnt_first = (bus.len_i < LEN_W'(room)) ? CNT_W'(bus.len_i) : room;
    first_hi  = off_ext + cnt_first;
    cnt_next  = (rem < LEN_W'(KEEP_W)) ? CNT_W'(rem) : CNT_W'(KEEP_W);
  end

  len_to_mask #(.KEEP_W(KEEP_W), .CNT_W(CNT_W)) u_hi   (.n(first_hi), .mask(hi_mask));
  len_to_mask #(.KEEP_W(KEEP_W), .CNT_W(CNT_W)) u_lo   (.n(off_ext),  .mask(lo_mask));
  len_to_mask #(.KEEP_W(KEEP_W), .CNT_W(CNT_W)) u_next (.n(cnt_next), .mask(next_mask));

  assign beat_take       = valid_q & bus.mask_ready_i;
  assign bus.len_ready_o = ~reset & ((state == IDLE) | (beat_take & last_q));
  assign accept          = bus.len_valid_i & bus.len_ready_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rem     <= '0;
      valid_q <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else if (accept && (bus.len_i != '0)) begin
      state   <= BUSY;
      valid_q <= 1'b1;
      mask_q  <= hi_mask & ~lo_mask;
      cnt_q   <= cnt_first;
      rem     <= bus.len_i - LEN_W'(cnt_first);
      last_q  <= (bus.len_i == LEN_W'(cnt_first));
    end else if (accept || (beat_take && last_q)) begin
      // Zero-length request or end of message with nothing new: back to idle.
      state   <= IDLE;
      valid_q <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      rem     <= '0;
    end else if (beat_take) begin
      mask_q  <= next_mask;
      cnt_q   <= cnt_next;
      rem     <= rem - LEN_W'(cnt_next);
      last_q  <= (rem == LEN_W'(cnt_next));
    end
  end

  assign bus.mask_valid_o = valid_q;
  assign bus.mask_o       = mask_q;
  assign bus.cnt_o        = cnt_q;
  assign bus.last_o       = last_q;
  assign bus.state        = state;

  mask_cnt_a: assert property (@(posedge clk) disable iff (reset)
    valid_q |-> ($countones(mask_q) == int'(cnt_q)));

  hold_a: assert property (@(posedge clk) disable iff (reset)
    (valid_q && !bus.mask_ready_i) |=>
      (valid_q && $stable(mask_q) && $stable(cnt_q) && $stable(last_q)));

endmodule

// File: tb/tb_msg_keep_gen.sv
// Directed and randomised stimulus for msg_keep_gen with a beat scoreboard.
module tb_msg_keep_gen;
  import msg_keep_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  msg_keep_gen_if bus ();

  msg_keep_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit rand_bp = 1'b0;

  // {last, cnt[3:0], mask[7:0]}
  logic [12:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference beat sequence built from shifted ones, independent of the RTL structure.
  task automatic push_msg(input int len, input int off);
    int    rem;
    int    c;
    keep_t m;
    bit    first;
    rem   = len;
    first = 1'b1;
    while (rem > 0) begin
      if (first) begin
        c = (rem < 8 - off) ? rem : 8 - off;
        m = 8'(((1 << c) - 1) << off);
      end else begin
        c = (rem < 8) ? rem : 8;
        m = 8'((1 << c) - 1);
      end
      rem  -= c;
      first = 1'b0;
      exp_q.push_back({rem == 0, 4'(c), m});
    end
  endtask

  task automatic send_req(input int len, input int off, output bit with_beat);
    bit got;
    got       = 1'b0;
    with_beat = 1'b0;
    bus.len_valid_i = 1'b1;
    bus.len_i       = 16'(len);
    bus.off_i       = 3'(off);
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.len_ready_o === 1'b1) begin
        with_beat = bus.mask_valid_o & bus.mask_ready_i;
        push_msg(len, off);
        got = 1'b1;
        break;
      end
    end
    check("req_accept", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    bus.len_valid_i = 1'b0;
    bus.len_i       = 16'($urandom);
    bus.off_i       = 3'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.mask_valid_o === 1'b0) break;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(bus.mask_valid_o), 32'd0);
    step(1);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.mask_valid_o === 1'b1 && bus.mask_ready_i === 1'b1) begin
      check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("beat", 32'({bus.last_o, bus.cnt_o, bus.mask_o}), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) bus.mask_ready_i = 1'($urandom_range(0, 1));
  end

  initial begin
    bit wb;
    bus.len_valid_i  = 1'b0;
    bus.len_i        = '0;
    bus.off_i        = '0;
    bus.mask_ready_i = 1'b1;

    #1;
    check("rst_valid", 32'(bus.mask_valid_o), 32'd0);
    check("rst_mask",  32'(bus.mask_o), 32'd0);
    check("rst_cnt",   32'(bus.cnt_o), 32'd0);
    check("rst_last",  32'(bus.last_o), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    step(2);
    reset = 1'b0;
    step(1);
    check("rst_ready", 32'(bus.len_ready_o), 32'd1);

    // Single beat, one-cycle latency
    send_req(5, 0, wb);
    check("t1_valid_lat", 32'(bus.mask_valid_o), 32'd1);
    check("t1_mask", 32'(bus.mask_o), 32'h1F);
    drain();
    check("t1_idle_ready", 32'(bus.len_ready_o), 32'd1);

    // Multi-beat and offset cases
    send_req(20, 0, wb);
    drain();
    send_req(3, 6, wb);
    drain();
    send_req(2, 6, wb);
    check("t3_single_last", 32'(bus.last_o), 32'd1);
    drain();

    // Backpressure holds the first beat
    bus.mask_ready_i = 1'b0;
    send_req(12, 0, wb);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(bus.mask_valid_o), 32'd1);
      check("bp_mask",  32'(bus.mask_o), 32'hFF);
      check("bp_cnt",   32'(bus.cnt_o), 32'd8);
      check("bp_ready", 32'(bus.len_ready_o), 32'd0);
      step(1);
    end
    bus.mask_ready_i = 1'b1;
    drain();

    // Back-to-back: second request taken with the last beat
    send_req(9, 0, wb);
    send_req(4, 2, wb);
    check("b2b_same_cycle", 32'(wb), 32'd1);
    check("b2b_valid", 32'(bus.mask_valid_o), 32'd1);
    check("b2b_mask",  32'(bus.mask_o), 32'h3C);
    drain();

    // Zero length: consumed, no beat
    send_req(0, 3, wb);
    check("len0_valid", 32'(bus.mask_valid_o), 32'd0);
    check("len0_ready", 32'(bus.len_ready_o), 32'd1);
    step(2);
    check("len0_still_idle", 32'(bus.mask_valid_o), 32'd0);

    // Reset in the middle of a message
    send_req(30, 0, wb);
    step(2);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_valid", 32'(bus.mask_valid_o), 32'd0);
    check("mid_rst_mask",  32'(bus.mask_o), 32'd0);
    check("mid_rst_cnt",   32'(bus.cnt_o), 32'd0);
    check("mid_rst_last",  32'(bus.last_o), 32'd0);
    step(1);
    reset = 1'b0;
    step(1);
    check("post_rst_state", 32'(bus.state), 32'(IDLE));
    check("post_rst_ready", 32'(bus.len_ready_o), 32'd1);
    send_req(1, 0, wb);
    check("post_rst_mask", 32'(bus.mask_o), 32'h01);
    check("post_rst_last", 32'(bus.last_o), 32'd1);
    drain();

    // Random lengths and offsets under random backpressure
    rand_bp = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send_req($urandom_range(1, 40), $urandom_range(0, 7), wb);
    end
    rand_bp = 1'b0;
    bus.mask_ready_i = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
